imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream from the UART receiver and writes it into instruction memory as 32-bit words.
- Holds the CPU in reset while a load is in progress.
- Sits between the UART RX block and the instruction memory write port. It enables reprogramming over serial without resynthesis.

Parameters:
ALEN, 32, address width of the instruction memory port
DEPTH_WORDS, 4096, instruction memory capacity in 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0
MAGIC, 8'hA5, frame start byte

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  ALEN  byte address of the word being written
mem_wdata  output  32  word to write
cpu_hold  output  1  keeps the CPU in reset while high
load_done  output  1  level; last frame completed successfully
load_error  output  1  level; last frame aborted
words_written  output  16  count of words written in the current/last frame

Behaviour:
- Reset (rst sampled high at a clk edge): state IDLE; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, load_done=0, load_error=0, words_written=0. Reset mid-frame abandons the frame and performs no further writes.
- A byte is consumed only on a cycle with rx_valid=1. Back-to-back rx_valid on consecutive cycles must be accepted with no loss.
- Frame format: MAGIC, LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 data bytes. Each word is little-endian: the first byte goes to [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, [CHK], DONE, ERROR.
- IDLE: bytes other than MAGIC are ignored. On MAGIC: go to LEN_LO, set cpu_hold=1, clear load_done/load_error, set words_written=0.
- LEN_LO: latch the low byte, go to LEN_HI.
- LEN_HI: latch the high byte, then:
  - N=0: go to DONE (or CHK when the optional feature is on).
  - N>DEPTH_WORDS: go to ERROR.
  - Otherwise: go to DATA with byte index 0 and word index 0.
- DATA: shift bytes into the word assembly register; the 2-bit byte index wraps 3->0.
  - On the 4th byte of a word, accepted at cycle t: at cycle t+1 mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+4*word_index, mem_wdata=assembled word. words_written increments in the same cycle as that write.
  - After word N-1 is written: go to DONE (or CHK).
  - Addresses never exceed BASE_ADDR+4*(DEPTH_WORDS-1).
- DONE: cpu_hold=0, load_done=1. A new MAGIC restarts at LEN_LO; other bytes are ignored.
- ERROR: cpu_hold stays 1, load_error=1, no writes. A new MAGIC restarts at LEN_LO; other bytes are ignored.
- A MAGIC value received inside LEN or DATA is treated as data, never as a restart.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Transitions take effect at the clk edge on which the byte is accepted. Outputs are registered.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte (or after LEN_HI when N=0), state CHK expects one byte equal to the XOR of all bytes from LEN_LO through the last data byte.
  - Match: go to DONE.
  - Mismatch: go to ERROR. Words already written stay in memory; cpu_hold remains 1.
  - The running XOR resets on MAGIC.
- Not defined: no CHK state; the frame ends after the last data byte.

Test Plan:
- Bytes A5 02 00 13 00 10 00 B7 00 00 80 -> mem_we pulses twice: addr 0x0 data 0x00100013, addr 0x4 data 0x800000B7. Then load_done=1, cpu_hold=0, words_written=2.
- Noise 00 FF 13 then a 1-word frame, all on back-to-back cycles -> noise ignored; exactly one write at addr 0x0; cpu_hold rises the cycle after A5 is accepted.
- A5 00 00 -> no writes, load_done=1 on the next cycle (checksum off).
- A5 01 10 (N=4097) -> load_error=1, cpu_hold=1, no writes. A following valid frame then completes with load_done=1, load_error=0.
- rst asserted after 6 data bytes of a 2-word frame -> one write already done; after reset all outputs are at reset values and no second write occurs.
- With IMEM_LOADER_CHECKSUM_EN: A5 01 00 13 00 00 00 then 12 -> load_done. The same frame ending 13 -> load_error=1, one write already issued.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: frames of MAGIC, LEN_LO, LEN_HI, then N little-endian 32-bit words written to imem.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (state CHK) before a frame is accepted.
module imem_loader #(
    parameter int unsigned      ALEN        = 32,
    parameter int unsigned      DEPTH_WORDS = 4096,
    parameter logic [ALEN-1:0]  BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]       MAGIC       = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            mem_we,
    output logic [ALEN-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_error,
    output logic [15:0]     words_written
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ALEN-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [15:0]       words_written_q, words_written_d;
    logic [15:0]       frame_len;
    logic              is_magic;
    logic              finish;

    assign frame_len = {rx_data, len_q[7:0]};
    assign is_magic  = rx_valid && (rx_data == MAGIC);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    // Running XOR over LEN_LO through the last data byte; cleared by any accepted MAGIC.
    always_comb begin
        chk_d = chk_q;
        if (rx_valid) begin
            if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR) && is_magic)
                chk_d = 8'h00;
            else if (state_q == S_LEN_LO || state_q == S_LEN_HI || state_q == S_DATA)
                chk_d = chk_q ^ rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) chk_q <= 8'h00;
        else     chk_q <= chk_d;
    end
`endif

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        byte_idx_d      = byte_idx_q;
        asm_d           = asm_q;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        cpu_hold_d      = cpu_hold_q;
        load_done_d     = load_done_q;
        load_error_d    = load_error_q;
        words_written_d = words_written_q;
        finish          = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (is_magic) begin
                    state_d         = S_LEN_LO;
                    cpu_hold_d      = 1'b1;
                    load_done_d     = 1'b0;
                    load_error_d    = 1'b0;
                    words_written_d = 16'd0;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d      = frame_len;
                    byte_idx_d = 2'd0;
                    if (frame_len == 16'd0) begin
                        finish = 1'b1;
                    end else if (32'(frame_len) > DEPTH_WORDS) begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    asm_d      = {rx_data, asm_q[23:8]};
                    // words_written doubles as the word index of the next write.
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d        = 1'b1;
                        mem_addr_d      = BASE_ADDR + ALEN'({words_written_q, 2'b00});
                        mem_wdata_d     = {rx_data, asm_q};
                        words_written_d = words_written_q + 16'd1;
                        if (words_written_q == len_q - 16'd1) finish = 1'b1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d     = S_DONE;
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d     = S_DONE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            len_q           <= 16'd0;
            byte_idx_q      <= 2'd0;
            asm_q           <= 24'd0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= BASE_ADDR;
            mem_wdata_q     <= 32'd0;
            cpu_hold_q      <= 1'b0;
            load_done_q     <= 1'b0;
            load_error_q    <= 1'b0;
            words_written_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            byte_idx_q      <= byte_idx_d;
            asm_q           <= asm_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            cpu_hold_q      <= cpu_hold_d;
            load_done_q     <= load_done_d;
            load_error_q    <= load_error_d;
            words_written_q <= words_written_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign load_done     = load_done_q;
    assign load_error    = load_error_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven on falling edges, outputs sampled on falling edges.
// Every memory write is matched against an expected queue of {addr, data} pairs.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_written;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_written(words_written)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic drop();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_chk(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(b);
`else
    if (b === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // scoreboard: every write must match the head of exp_q
  always @(negedge clk) begin : write_mon
    logic [63:0] e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {mem_addr, mem_wdata}, e);
      end
    end
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_error", 64'(load_error), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    rst = 1'b0;

    // two-word frame
    exp_q.push_back({32'h0, 32'h0010_0013});
    exp_q.push_back({32'h4, 32'h8000_00B7});
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h10); send(8'h00);
    send(8'hB7); send(8'h00); send(8'h00); send(8'h80);
    send_chk(8'h36);
    drop();
    check("t1_load_done", 64'(load_done), 64'd1);
    check("t1_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t1_words", 64'(words_written), 64'd2);
    settle();
    check("t1_all_writes", 64'(exp_q.size()), 64'd0);
    check("t1_addr_hold", 64'(mem_addr), 64'h4);
    check("t1_wdata_hold", 64'(mem_wdata), 64'h8000_00B7);

    // noise then a one-word frame, back to back; A5 inside data is plain data
    exp_q.push_back({32'h0, 32'hDEAD_BEA5});
    send(8'h00); send(8'hFF); send(8'h13);
    @(negedge clk);
    check("t2_noise_hold", 64'(cpu_hold), 64'd0);
    check("t2_noise_done", 64'(load_done), 64'd1);
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    check("t2_hold_rise", 64'(cpu_hold), 64'd1);
    check("t2_done_clr", 64'(load_done), 64'd0);
    check("t2_words_clr", 64'(words_written), 64'd0);
    rx_data = 8'h01;
    send(8'h00);
    send(8'hA5); send(8'hBE); send(8'hAD); send(8'hDE);
    send_chk(8'h69);
    drop();
    check("t2_load_done", 64'(load_done), 64'd1);
    check("t2_words", 64'(words_written), 64'd1);
    settle();
    check("t2_all_writes", 64'(exp_q.size()), 64'd0);

    // zero-length frame
    send(8'hA5);
    @(negedge clk);
    check("t3_done_clr", 64'(load_done), 64'd0);
    rx_data = 8'h00;
    send(8'h00);
    send_chk(8'h00);
    drop();
    check("t3_load_done", 64'(load_done), 64'd1);
    check("t3_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t3_words", 64'(words_written), 64'd0);

    // N=4097 is too large
    send(8'hA5); send(8'h01); send(8'h10);
    drop();
    check("t4_load_error", 64'(load_error), 64'd1);
    check("t4_cpu_hold", 64'(cpu_hold), 64'd1);
    check("t4_load_done", 64'(load_done), 64'd0);
    send(8'h55);
    drop();
    check("t4_err_sticky", 64'(load_error), 64'd1);
    exp_q.push_back({32'h0, 32'h1234_5678});
    send(8'hA5);
    @(negedge clk);
    check("t4_err_clr", 64'(load_error), 64'd0);
    rx_data = 8'h01;
    send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send_chk(8'h09);
    drop();
    check("t4_recover_done", 64'(load_done), 64'd1);
    check("t4_recover_err", 64'(load_error), 64'd0);
    settle();
    check("t4_all_writes", 64'(exp_q.size()), 64'd0);

    // N=4096 is the largest accepted length
    send(8'hA5); send(8'h00); send(8'h10);
    drop();
    check("t4_max_err", 64'(load_error), 64'd0);
    check("t4_max_hold", 64'(cpu_hold), 64'd1);

    // reset in the middle of a two-word frame
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.push_back({32'h0, 32'h4433_2211});
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    @(negedge clk);
    check("t5_words_mid", 64'(words_written), 64'd1);
    rx_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_hold", 64'(cpu_hold), 64'd0);
    check("t5_rst_words", 64'(words_written), 64'd0);
    check("t5_rst_we", 64'(mem_we), 64'd0);
    check("t5_rst_addr", 64'(mem_addr), 64'd0);
    check("t5_rst_wdata", 64'(mem_wdata), 64'd0);
    send(8'h77); send(8'h88);
    drop();
    settle();
    check("t5_one_write", 64'(exp_q.size()), 64'd0);
    check("t5_idle_done", 64'(load_done), 64'd0);
    check("t5_idle_hold", 64'(cpu_hold), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_q.push_back({32'h0, 32'h0000_0013});
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h12);
    drop();
    check("t6_chk_ok_done", 64'(load_done), 64'd1);
    check("t6_chk_ok_hold", 64'(cpu_hold), 64'd0);
    exp_q.push_back({32'h0, 32'h0000_0013});
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13);
    drop();
    check("t6_chk_bad_err", 64'(load_error), 64'd1);
    check("t6_chk_bad_hold", 64'(cpu_hold), 64'd1);
    check("t6_chk_bad_words", 64'(words_written), 64'd1);
    settle();
    check("t6_all_writes", 64'(exp_q.size()), 64'd0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
